// File: rtl/adc_capture_if.sv
// Sample, trigger and readout signals of adc_capture, bundled for the top-level port.
// The bench drives through master; the capture block uses slave.
interface adc_capture_if;
    logic        [13:0] ADC_D;
    logic               ADC_OR;
    logic               ARM;
    logic               TRIG_EN;
    logic signed [13:0] TRIG_LEVEL;
    logic               RD_EN;
    logic signed [13:0] RD_DATA;
    logic               RD_VALID;
    logic               BUSY;
    logic               DONE;
    logic               OVR;

    modport master (
        output ADC_D, ADC_OR, ARM, TRIG_EN, TRIG_LEVEL, RD_EN,
        input  RD_DATA, RD_VALID, BUSY, DONE, OVR
    );

    modport slave (
        input  ADC_D, ADC_OR, ARM, TRIG_EN, TRIG_LEVEL, RD_EN,
        output RD_DATA, RD_VALID, BUSY, DONE, OVR
    );
endinterface

// File: rtl/adc_capture.sv
// Triggered ADC snapshot: one registered input stage, level/immediate trigger,
// a DEPTH x 14 single-port buffer and a sequential one-sample-per-cycle readout.
module adc_capture #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic         CLK,
    input  logic         RST,
    adc_capture_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, READY} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    // Offset binary to two's complement: flipping the MSB subtracts mid-scale.
    function automatic logic signed [13:0] ob_to_tc(input logic [13:0] s);
        return $signed({~s[13], s[12:0]});
    endfunction

    logic        [13:0] adc_q, adc_d;
    logic               or_q, or_d;
    logic signed [13:0] prev_q, prev_d;
    logic signed [13:0] cur_s;
    logic               trig;

    state_t             state_q, state_d;
    logic    [AW-1:0]   wptr_q, wptr_d;
    logic    [AW-1:0]   rptr_q, rptr_d;
    logic               ovr_q, ovr_d;
    logic               rd_valid_q, rd_valid_d;
    logic               arm_acc;

    logic               mem_we, mem_re;
    logic    [AW-1:0]   mem_addr;
    logic signed [13:0] mem [DEPTH];
    logic signed [13:0] rd_word_q;

    // ---- input stage: register, convert, remember the previous sample
    always_comb begin
        adc_d  = bus.ADC_D;
        or_d   = bus.ADC_OR;
        cur_s  = ob_to_tc(adc_q);
        prev_d = cur_s;
        trig   = (prev_q < bus.TRIG_LEVEL) && (cur_s >= bus.TRIG_LEVEL);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            adc_q  <= '0;
            or_q   <= 1'b0;
            prev_q <= '0;
        end else begin
            adc_q  <= adc_d;
            or_q   <= or_d;
            prev_q <= prev_d;
        end
    end

    // ---- control: acquisition sequencing and readout pointer
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        ovr_d      = ovr_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        arm_acc    = bus.ARM && ((state_q == IDLE) || (state_q == READY));

        case (state_q)
            IDLE: ;
            WAIT_TRIG: begin
                if (trig) begin
                    mem_we  = 1'b1;
                    wptr_d  = wptr_q + 1'b1;
                    ovr_d   = ovr_q | or_q;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                mem_we = 1'b1;
                wptr_d = wptr_q + 1'b1;
                ovr_d  = ovr_q | or_q;
                if (wptr_q == LAST_ADDR) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (!bus.ARM && bus.RD_EN) begin
                    mem_re     = 1'b1;
                    rd_valid_d = 1'b1;
                    rptr_d     = rptr_q + 1'b1;
                    if (rptr_q == LAST_ADDR) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A re-arm from READY abandons any unread samples.
        if (arm_acc) begin
            ovr_d   = 1'b0;
            wptr_d  = '0;
            rptr_d  = '0;
            state_d = bus.TRIG_EN ? WAIT_TRIG : CAPTURE;
        end

        mem_addr = (state_q == READY) ? rptr_q : wptr_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            ovr_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ovr_q      <= ovr_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // ---- buffer: writes and reads are confined to disjoint states
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_addr] <= cur_s;
        end
        if (mem_re) begin
            rd_word_q <= mem[mem_addr];
        end
    end

    // Gating by RD_VALID keeps stale buffer words off the port after reset.
    assign bus.RD_DATA  = rd_valid_q ? rd_word_q : '0;
    assign bus.RD_VALID = rd_valid_q;
    assign bus.BUSY     = (state_q == WAIT_TRIG) || (state_q == CAPTURE);
    assign bus.DONE     = (state_q == READY);
    assign bus.OVR      = ovr_q;
endmodule

// File: tb/tb_adc_capture.sv
// Randomized bench for adc_capture: a behavioural acquisition model predicts
// status and readout data; a negedge monitor checks the DUT against it.
module tb_adc_capture;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic CLK = 1'b0;
    logic RST;

    adc_capture_if bus ();

    adc_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: phase 0 idle, 1 armed waiting, 2 filling, 3 holding.
    int  m_phase = 0;
    int  m_buf [DEPTH];
    int  m_wi = 0, m_ri = 0;
    bit  m_ovr = 1'b0;
    int  m_c1 = -8192, m_c2 = 0;   // samples seen one and two edges ago
    bit  m_o1 = 1'b0;
    int  m_lvl;
    int  exp_q [$];

    bit          first_pending = 1'b0;
    logic [13:0] first_act = '0;

    int          src_mode = 0;     // 0 random, 1 ramp, 2 constant
    logic [13:0] src_val  = '0;
    int          ramp_cnt = 0;
    int          or_cd    = 0;

    function automatic int ob2int(input logic [13:0] d);
        return int'(d) - 8192;
    endfunction

    function automatic void model_arm();
        m_ovr   = 1'b0;
        m_wi    = 0;
        m_ri    = 0;
        m_phase = bus.TRIG_EN ? 1 : 2;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_phase = 0; m_wi = 0; m_ri = 0; m_ovr = 1'b0;
            m_c1 = -8192; m_c2 = 0; m_o1 = 1'b0;
            exp_q.delete();
        end else begin
            m_lvl = int'(bus.TRIG_LEVEL);
            case (m_phase)
                0: if (bus.ARM) model_arm();
                1: if (m_c2 < m_lvl && m_c1 >= m_lvl) begin
                       m_buf[0] = m_c1; m_ovr |= m_o1; m_wi = 1; m_phase = 2;
                   end
                2: begin
                       m_buf[m_wi] = m_c1; m_ovr |= m_o1; m_wi++;
                       if (m_wi == DEPTH) m_phase = 3;
                   end
                default: begin
                       if (bus.ARM) model_arm();
                       else if (bus.RD_EN) begin
                           exp_q.push_back(m_buf[m_ri]);
                           m_ri++;
                           if (m_ri == DEPTH) m_phase = 0;
                       end
                   end
            endcase
            m_c2 = m_c1;
            m_c1 = ob2int(bus.ADC_D);
            m_o1 = bus.ADC_OR;
        end
    end

    int e;
    always @(negedge CLK) begin
        if (!RST) begin
            chk("status_busy_done_ovr", int'({bus.BUSY, bus.DONE, bus.OVR}),
                int'({(m_phase == 1 || m_phase == 2), (m_phase == 3), m_ovr}));
            if (bus.RD_VALID) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_valid_unexpected: got RD_VALID=1 data=%0d, expected no read", $signed(bus.RD_DATA));
                end else begin
                    e = exp_q.pop_front();
                    if (int'(bus.RD_DATA) != e) begin
                        n_fail++;
                        $display("FAIL rd_data: got %0d, expected %0d", $signed(bus.RD_DATA), e);
                    end
                    if (first_pending) begin
                        first_act     = bus.RD_DATA;
                        first_pending = 1'b0;
                    end
                end
            end
            if (exp_q.size() != 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_valid_missing: got RD_VALID=%0d, expected 1", bus.RD_VALID);
                exp_q.delete();
            end
        end
    end

    task automatic step();
        @(negedge CLK);
        bus.ARM   = 1'b0;
        bus.RD_EN = 1'b0;
        case (src_mode)
            0: bus.ADC_D = 14'($urandom);
            1: begin bus.ADC_D = 14'(ramp_cnt); ramp_cnt++; end
            default: bus.ADC_D = src_val;
        endcase
        bus.ADC_OR = (or_cd == 1);
        if (or_cd > 0) or_cd--;
    endtask

    task automatic do_arm(input bit te, input logic [13:0] lvl, input bit with_rd);
        step();
        bus.TRIG_EN    = te;
        bus.TRIG_LEVEL = lvl;
        bus.ARM        = 1'b1;
        bus.RD_EN      = with_rd;
    endtask

    task automatic wait_done(output int busy_n);
        int g;
        busy_n = 0;
        g      = 0;
        do begin
            step();
            if (bus.BUSY) busy_n++;
            if (!bus.DONE) bus.RD_EN = 1'($urandom_range(1));
            g++;
        end while (!bus.DONE && g < 4 * DEPTH);
        chk("done_reached", int'(bus.DONE), 1);
    endtask

    task automatic readout(input int n, input int pct);
        int cnt, g;
        cnt = 0;
        g   = 0;
        while (cnt < n && g < 8 * DEPTH) begin
            step();
            if (bus.DONE && $urandom_range(99) < pct) begin
                bus.RD_EN = 1'b1;
                cnt++;
            end
            g++;
        end
        chk("reads_issued", cnt, n);
        step();
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bn, lvl, rv;
        RST = 1'b1;
        bus.ADC_D = '0; bus.ADC_OR = 1'b0; bus.ARM = 1'b0;
        bus.TRIG_EN = 1'b0; bus.TRIG_LEVEL = '0; bus.RD_EN = 1'b0;
        #1;
        chk("rst_busy", int'(bus.BUSY), 0);
        chk("rst_done", int'(bus.DONE), 0);
        chk("rst_ovr", int'(bus.OVR), 0);
        chk("rst_rd_valid", int'(bus.RD_VALID), 0);
        chk("rst_rd_data", int'(bus.RD_DATA), 0);
        repeat (3) step();
        RST = 1'b0;

        // Immediate capture of a ramp.
        src_mode = 1; ramp_cnt = 0;
        do_arm(1'b0, 14'd0, 1'b0);
        wait_done(bn);
        chk("imm_busy_cycles", bn, DEPTH);
        first_pending = 1'b1;
        readout(DEPTH, 75);
        chk("imm_first_rd", int'(first_act), 'h2000);
        chk("imm_done_after_read", int'(bus.DONE), 0);

        // Level trigger at 0: a falling step while armed must not fire.
        src_mode = 2; src_val = 14'h2010;
        repeat (5) step();
        do_arm(1'b1, 14'd0, 1'b0);
        repeat (10) step();
        src_val = 14'h1F00;
        repeat (10) step();
        src_val = 14'h2010;
        repeat (3) step();
        src_val = 14'h1F00;
        repeat (3) step();
        src_mode = 0;
        wait_done(bn);
        first_pending = 1'b1;
        readout(DEPTH, 90);
        chk("lvl_first_rd", int'(first_act), 'h0010);

        // Constant input above the level never crosses; ARM while waiting is ignored.
        src_mode = 2; src_val = 14'h3FFF;
        repeat (4) step();
        do_arm(1'b1, 14'd100, 1'b0);
        for (int i = 0; i < 5000; i++) begin
            step();
            if (i == 2500) bus.ARM = 1'b1;
        end
        chk("nocross_busy", int'(bus.BUSY), 1);
        chk("nocross_done", int'(bus.DONE), 0);
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;

        // Over-range pulse, partial readout, then re-arm racing a read.
        src_mode = 0;
        do_arm(1'b0, 14'd0, 1'b0);
        repeat (200) step();
        or_cd = 1;
        wait_done(bn);
        chk("ovr_in_ready", int'(bus.OVR), 1);
        readout(10, 100);
        do_arm(1'b0, 14'd0, 1'b1);
        step();
        chk("ovr_cleared_by_arm", int'(bus.OVR), 0);
        chk("rearm_busy", int'(bus.BUSY), 1);
        wait_done(bn);
        readout(DEPTH, 60);

        // Random levels on random data.
        for (int t = 0; t < 3; t++) begin
            lvl = int'($urandom_range(8000)) - 4000;
            do_arm(1'b1, 14'(lvl), 1'b0);
            if (t == 1) or_cd = int'($urandom_range(300, 50));
            wait_done(bn);
            readout(DEPTH, 80);
        end

        // Reset in the middle of a capture.
        do_arm(1'b0, 14'd0, 1'b0);
        repeat (50) step();
        or_cd = 1;
        repeat (100) step();
        chk("pre_rst_ovr", int'(bus.OVR), 1);
        #2 RST = 1'b1;
        #1;
        chk("midcap_rst_busy", int'(bus.BUSY), 0);
        chk("midcap_rst_ovr", int'(bus.OVR), 0);
        chk("midcap_rst_done", int'(bus.DONE), 0);
        step();
        RST = 1'b0;
        rv = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            bus.RD_EN = 1'b1;
            if (bus.RD_VALID) rv++;
        end
        step();
        if (bus.RD_VALID) rv++;
        chk("post_rst_rd_valid_count", rv, 0);

        // Reset in the middle of a readout.
        do_arm(1'b0, 14'd0, 1'b0);
        wait_done(bn);
        for (int i = 0; i < 5; i++) begin
            step();
            bus.RD_EN = 1'b1;
        end
        step();
        bus.RD_EN = 1'b1;
        chk("pre_rst_rd_valid", int'(bus.RD_VALID), 1);
        #2 RST = 1'b1;
        #1;
        chk("midrd_rst_rd_valid", int'(bus.RD_VALID), 0);
        chk("midrd_rst_rd_data", int'(bus.RD_DATA), 0);
        chk("midrd_rst_done", int'(bus.DONE), 0);
        step();
        RST = 1'b0;
        repeat (5) begin
            step();
            bus.RD_EN = 1'b1;
        end
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
